// File: rtl/spi_target.sv
// SPI mode-0 target endpoint. All SPI pins are oversampled in the i_clk
// domain; the core side exchanges bytes over a valid/ready TX port and a
// pulse-qualified RX port. A single holding register buffers the next
// response byte; when it is empty at a load point IDLE_BYTE is sent instead.
module spi_target #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_spi_sck,
    input  logic       i_spi_mosi,
    input  logic       i_spi_ss,
    output logic       o_spi_miso,
    output logic       o_spi_miso_oe,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_tx_underrun,
    output logic       o_frame_start,
    output logic       o_frame_end,
    output logic       o_busy
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    // Synchronizer chains plus one registered copy for edge detection.
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   sck_prev_q;
    logic                   ss_prev_q;
    logic                   armed_q;
    logic                   armed_d;

    logic sck_s;
    logic mosi_s;
    logic ss_s;
    logic sck_rise_s;
    logic sck_fall_s;
    logic ss_fall_s;
    logic ss_rise_s;

    // Protocol state.
    state_e     state_q,     state_d;
    logic [2:0] cnt_q,       cnt_d;
    logic [7:0] rx_sh_q,     rx_sh_d;
    logic [7:0] tx_sh_q,     tx_sh_d;
    logic [7:0] hold_q,      hold_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] rx_data_q,   rx_data_d;
    logic       rx_valid_q,  rx_valid_d;
    logic       underrun_q,  underrun_d;
    logic       fstart_q,    fstart_d;
    logic       fend_q,      fend_d;
    logic       miso_q,      miso_d;
    logic       load_s;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign ss_s   = ss_sync_q[SYNC_STAGES-1];

    assign sck_rise_s = sck_s & ~sck_prev_q;
    assign sck_fall_s = ~sck_s & sck_prev_q;
    // A select fall only counts once SS has been seen high on real pin
    // samples, so a master holding SS low across reset cannot start a frame.
    assign ss_fall_s  = armed_q & ss_prev_q & ~ss_s;
    assign ss_rise_s  = ss_s & ~ss_prev_q;

    // fill_q marks which synchronizer stages hold genuine post-reset samples.
    assign armed_d = armed_q | (fill_q[SYNC_STAGES-1] & ss_s);

    // Synchronize SPI pins and keep the previous synchronized values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '1;
            fill_q      <= '0;
            sck_prev_q  <= 1'b0;
            ss_prev_q   <= 1'b1;
            armed_q     <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], i_spi_sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_spi_mosi};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], i_spi_ss};
            fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            sck_prev_q  <= sck_s;
            ss_prev_q   <= ss_s;
            armed_q     <= armed_d;
        end
    end

    // Frame state, bit counter, shift registers and TX holding register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            rx_sh_q     <= 8'h00;
            tx_sh_q     <= 8'h00;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            fstart_q    <= 1'b0;
            fend_q      <= 1'b0;
            miso_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_sh_q     <= rx_sh_d;
            tx_sh_q     <= tx_sh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            fstart_q    <= fstart_d;
            fend_q      <= fend_d;
            miso_q      <= miso_d;
        end
    end

    // Next-state logic: SS rise has priority over SCK edges; loads and TX
    // writes in the same cycle see the pre-write holding state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_sh_d     = rx_sh_q;
        tx_sh_d     = tx_sh_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        fstart_d    = 1'b0;
        fend_d      = 1'b0;
        miso_d      = miso_q;
        load_s      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b1;
                if (ss_fall_s) begin
                    state_d  = ST_ACTIVE;
                    fstart_d = 1'b1;
                    cnt_d    = 3'd0;
                    load_s   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (ss_rise_s) begin
                    state_d = ST_IDLE;
                    fend_d  = 1'b1;
                    miso_d  = 1'b1;
                    cnt_d   = 3'd0;
                    rx_sh_d = 8'h00;
                end else if (sck_rise_s) begin
                    rx_sh_d = {rx_sh_q[6:0], mosi_s};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        rx_data_d  = {rx_sh_q[6:0], mosi_s};
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_valid_d = 1'b0;
                    end
                end else if (sck_fall_s) begin
                    if (cnt_q != 3'd0) begin
                        tx_sh_d = {tx_sh_q[6:0], 1'b0};
                        miso_d  = tx_sh_q[6];
                    end else begin
                        load_s = 1'b1;
                    end
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                miso_d  = 1'b1;
            end
        endcase

        if (load_s) begin
            if (hold_full_q) begin
                tx_sh_d     = hold_q;
                miso_d      = hold_q[7];
                hold_full_d = 1'b0;
            end else begin
                tx_sh_d    = IDLE_BYTE;
                miso_d     = IDLE_BYTE[7];
                underrun_d = 1'b1;
            end
        end else begin
            tx_sh_d = tx_sh_d;
        end

        if (i_tx_valid && !hold_full_q) begin
            hold_d      = i_tx_data;
            hold_full_d = 1'b1;
        end else begin
            hold_d = hold_d;
        end
    end

    assign o_spi_miso    = miso_q;
    assign o_spi_miso_oe = (state_q == ST_ACTIVE);
    assign o_busy        = (state_q == ST_ACTIVE);
    assign o_tx_ready    = ~hold_full_q;
    assign o_rx_data     = rx_data_q;
    assign o_rx_valid    = rx_valid_q;
    assign o_tx_underrun = underrun_q;
    assign o_frame_start = fstart_q;
    assign o_frame_end   = fend_q;

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: a bit-banged SPI master with a transaction-level
// model of the TX holding register (one slot, IDLE byte on empty loads)
// and a queue of bytes the target must report.
`timescale 1ns/1ps
module tb_spi_target;
    localparam int SYNC = 2;
    localparam int H    = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sck;
    logic       mosi;
    logic       ss;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       frame_start;
    logic       frame_end;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int obs_start = 0, obs_end = 0, obs_und = 0;
    int exp_start = 0, exp_end = 0, exp_und = 0;

    logic [7:0] exp_rx[$];
    logic [7:0] mhold;
    bit         mhold_full = 1'b0;
    logic [7:0] mo[8];
    logic [7:0] got[8];
    logic [7:0] exp_miso[8];
    logic [7:0] push_byte[8];
    bit         push_plan[8];
    bit         rxv_prev = 1'b0;

    always #5 clk = ~clk;

    spi_target #(.SYNC_STAGES(SYNC), .IDLE_BYTE(8'hFF)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_spi_sck     (sck),
        .i_spi_mosi    (mosi),
        .i_spi_ss      (ss),
        .o_spi_miso    (miso),
        .o_spi_miso_oe (miso_oe),
        .i_tx_data     (tx_data),
        .i_tx_valid    (tx_valid),
        .o_tx_ready    (tx_ready),
        .o_rx_data     (rx_data),
        .o_rx_valid    (rx_valid),
        .o_tx_underrun (tx_underrun),
        .o_frame_start (frame_start),
        .o_frame_end   (frame_end),
        .o_busy        (busy)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model of one load point: take the held byte, or send FF and count an underrun.
    function automatic void model_load(input int k);
        if (mhold_full) begin
            exp_miso[k] = mhold;
            mhold_full  = 1'b0;
        end else begin
            exp_miso[k] = 8'hFF;
            exp_und++;
        end
    endfunction

    task automatic tx_push(input logic [7:0] v);
        chk("tx_ready_vs_model", {31'd0, tx_ready}, {31'd0, !mhold_full});
        if (!mhold_full) begin
            tx_data  = v;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid   = 1'b0;
            mhold      = v;
            mhold_full = 1'b1;
            chk("tx_ready_after_write", {31'd0, tx_ready}, 32'd0);
        end
    endtask

    task automatic clear_plan();
        for (int k = 0; k < 8; k++) begin
            push_plan[k] = 1'b0;
            push_byte[k] = 8'h00;
        end
    endtask

    // One SS-low frame of n bytes; abort_rises>0 raises SS after that many
    // rises of the last byte. Complete frames end with SCK still high.
    task automatic run_frame(input int n, input int abort_rises, input bit collide,
                             input logic [7:0] col_byte, output int n_done);
        bit stop;
        stop   = 1'b0;
        n_done = 0;
        @(negedge clk);
        ss = 1'b0;
        if (collide) begin
            repeat (SYNC) @(posedge clk);
            @(negedge clk);
            tx_data  = col_byte;
            tx_valid = 1'b1;
            model_load(0);
            mhold      = col_byte;
            mhold_full = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
            chk("collide_frame_start", {31'd0, frame_start}, 32'd1);
            chk("collide_underrun", {31'd0, tx_underrun}, 32'd1);
            chk("collide_ready_low", {31'd0, tx_ready}, 32'd0);
        end else begin
            model_load(0);
        end
        wait_cyc(2 * H);
        chk("busy_in_frame", {31'd0, busy}, 32'd1);
        chk("oe_in_frame", {31'd0, miso_oe}, 32'd1);
        for (int k = 0; k < n && !stop; k++) begin
            for (int b = 7; b >= 0 && !stop; b--) begin
                if (k == n - 1 && abort_rises > 0 && (7 - b) == abort_rises) begin
                    stop = 1'b1;
                end else begin
                    mosi = mo[k][b];
                    wait_cyc(H);
                    got[k][b] = miso;
                    sck = 1'b1;
                    if (b == 0) begin
                        exp_rx.push_back(mo[k]);
                        n_done++;
                    end
                    wait_cyc(H / 2);
                    if (b == 3 && push_plan[k]) tx_push(push_byte[k]);
                    wait_cyc(H / 2);
                    if (!(k == n - 1 && b == 0)) begin
                        sck = 1'b0;
                        if (b == 0) model_load(k + 1);
                    end
                end
            end
        end
        ss = 1'b1;
        wait_cyc(2 * H);
        exp_start++;
        exp_end++;
        chk("busy_after_frame", {31'd0, busy}, 32'd0);
        chk("oe_after_frame", {31'd0, miso_oe}, 32'd0);
        chk("miso_idle_high", {31'd0, miso}, 32'd1);
        chk("frame_start_count", obs_start, exp_start);
        chk("frame_end_count", obs_end, exp_end);
        chk("underrun_count", obs_und, exp_und);
        chk("rx_all_delivered", exp_rx.size(), 0);
        for (int k = 0; k < n_done; k++) chk("miso_byte", {24'd0, got[k]}, {24'd0, exp_miso[k]});
        sck = 1'b0;
        wait_cyc(H);
    endtask

    // Per-cycle compare: every RX pulse must match the next expected byte,
    // last exactly one cycle, and all pulses are counted for frame checks.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rx_valid) begin
                if (exp_rx.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_unexpected actual=%0h expected=none t=%0t", rx_data, $time);
                end else begin
                    chk("rx_data", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
                end
                chk("rx_valid_single", {31'd0, rxv_prev}, 32'd0);
            end
            if (frame_start) obs_start++;
            if (frame_end)   obs_end++;
            if (tx_underrun) obs_und++;
            rxv_prev = rx_valid;
        end else begin
            rxv_prev = 1'b0;
        end
    end

    initial begin
        #(800_000);
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        int n;
        int ab;
        int und0;
        rst_n    = 1'b0;
        ss       = 1'b0;
        sck      = 1'b0;
        mosi     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        clear_plan();

        // Reset with SS low and SCK toggling, then keep toggling after release.
        for (int i = 0; i < 10; i++) begin
            wait_cyc(3);
            sck  = ~sck;
            mosi = ~mosi;
        end
        sck = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_cyc(6);
            sck = ~sck;
        end
        chk("rst_miso", {31'd0, miso}, 32'd1);
        chk("rst_oe", {31'd0, miso_oe}, 32'd0);
        chk("rst_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        ss = 1'b1;
        wait_cyc(20);
        chk("rst_no_frame_start", obs_start, 0);
        chk("rst_no_frame_end", obs_end, 0);
        chk("rst_no_underrun", obs_und, 0);

        // Single byte.
        tx_push(8'hA5);
        mo[0] = 8'h3C;
        run_frame(1, 0, 1'b0, 8'h00, nd);
        chk("single_miso", {24'd0, got[0]}, 32'h0000_00A5);
        chk("single_rx", {24'd0, rx_data}, 32'h0000_003C);
        chk("single_ready", {31'd0, tx_ready}, 32'd1);
        chk("single_underruns", obs_und, 0);

        // Multi-byte with the second response written mid-frame.
        tx_push(8'h01);
        mo[0] = 8'h40; mo[1] = 8'h00; mo[2] = 8'h95;
        push_plan[0] = 1'b1; push_byte[0] = 8'h02;
        und0 = obs_und;
        run_frame(3, 0, 1'b0, 8'h00, nd);
        chk("multi_miso0", {24'd0, got[0]}, 32'h0000_0001);
        chk("multi_miso1", {24'd0, got[1]}, 32'h0000_0002);
        chk("multi_miso2", {24'd0, got[2]}, 32'h0000_00FF);
        chk("multi_one_underrun", obs_und - und0, 1);
        chk("multi_rx_last", {24'd0, rx_data}, 32'h0000_0095);
        clear_plan();

        // Underrun at frame start.
        mo[0] = 8'h77;
        und0 = obs_und;
        run_frame(1, 0, 1'b0, 8'h00, nd);
        chk("start_underrun_miso", {24'd0, got[0]}, 32'h0000_00FF);
        chk("start_underrun_pulse", obs_und - und0, 1);
        chk("start_underrun_rx", {24'd0, rx_data}, 32'h0000_0077);

        // Abort after 5 rises, then a clean frame.
        mo[0] = 8'hE6;
        run_frame(1, 5, 1'b0, 8'h00, nd);
        chk("abort_rx_kept", {24'd0, rx_data}, 32'h0000_0077);
        mo[0] = 8'hC3;
        run_frame(1, 0, 1'b0, 8'h00, nd);
        chk("after_abort_rx", {24'd0, rx_data}, 32'h0000_00C3);

        // TX write in the very cycle of the frame-start load.
        chk("collide_ready_before", {31'd0, tx_ready}, 32'd1);
        mo[0] = 8'h12; mo[1] = 8'h34;
        run_frame(2, 0, 1'b1, 8'h5A, nd);
        chk("collide_miso0", {24'd0, got[0]}, 32'h0000_00FF);
        chk("collide_miso1", {24'd0, got[1]}, 32'h0000_005A);

        // Randomized frames.
        for (int f = 0; f < 20; f++) begin
            n  = $urandom_range(1, 4);
            ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
            for (int k = 0; k < 8; k++) begin
                mo[k]        = 8'($urandom);
                push_plan[k] = bit'($urandom_range(0, 1));
                push_byte[k] = 8'($urandom);
            end
            if ($urandom_range(0, 1) == 1) tx_push(8'($urandom));
            run_frame(n, ab, 1'b0, 8'h00, nd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- SPI mode-0 target (slave) endpoint: the responder side of the SD/SPI master link that the SOC drives.
- Lets a second FPGA/SOC instance, or a bench-side SD-card emulator, receive command bytes and return response bytes over i_spi_sck/i_spi_mosi/i_spi_ss/o_spi_miso.
- All SPI inputs are oversampled in the i_clk domain; the core side is a byte-wide valid/ready interface.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on SCK, MOSI and SS (legal values ≥2).
- IDLE_BYTE, 8'hFF: byte shifted out when no TX byte is pending.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_spi_sck  in  1  SPI clock from master, CPOL=0
- i_spi_mosi  in  1  master-out data
- i_spi_ss  in  1  active-low select
- o_spi_miso  out  1  target-out data
- o_spi_miso_oe  out  1  MISO output enable, 1 while selected
- i_tx_data  in  8  next response byte
- i_tx_valid  in  1  tx byte offered
- o_tx_ready  out  1  tx holding register empty
- o_rx_data  out  8  last complete received byte
- o_rx_valid  out  1  one-cycle pulse, o_rx_data new
- o_tx_underrun  out  1  one-cycle pulse, IDLE_BYTE was loaded
- o_frame_start  out  1  one-cycle pulse on synchronized SS fall
- o_frame_end  out  1  one-cycle pulse on synchronized SS rise
- o_busy  out  1  synchronized SS asserted

Behaviour:
Synchronization and clocking:
- SCK, MOSI and SS each pass through SYNC_STAGES flops. Edges are detected against one further registered copy.
- Master must hold SCK high and low for ≥ SYNC_STAGES+2 i_clk cycles each. Faster SCK is out of spec.

Reset:
- Synchronizers preset to SCK=0, SS=1.
- Outputs: o_spi_miso=1, o_spi_miso_oe=0, o_tx_ready=1, o_rx_data=0.
- All pulses 0, o_busy=0, bit counter 0, shift registers 0, holding register empty.
- Reset mid-frame aborts the frame with no pulses. After reset release, the frame restarts only on a fresh SS fall.

States: IDLE (SS high), ACTIVE (SS low).

IDLE → ACTIVE on synchronized SS fall:
- o_frame_start pulses; o_busy=1; o_spi_miso_oe=1; bit counter=0.
- TX shift register loads the holding byte, emptying the holding register, or loads IDLE_BYTE with an o_tx_underrun pulse.
- o_spi_miso = shift MSB in the same cycle as the load.

ACTIVE, on each synchronized SCK rise:
- Shift the synchronized MOSI into the RX shift register, MSB first. Increment the bit counter, 3-bit, wraps 7→0.
- On the 8th rise (counter 7→0): o_rx_data ← completed byte, and o_rx_valid is high the next cycle for exactly one cycle. No back-pressure: an unread byte is overwritten.

ACTIVE, on each synchronized SCK fall:
- Counter ≠ 0: shift TX left; o_spi_miso = new MSB.
- Counter = 0, i.e. the fall after the 8th rise: load the next byte using the same holding/underrun rule as the SS fall, so a continuous multi-byte frame is supported.

ACTIVE → IDLE on synchronized SS rise (checked before SCK edges in the same cycle):
- o_frame_end pulses; o_busy=0; o_spi_miso_oe=0; o_spi_miso=1.
- Partial RX byte is discarded with no o_rx_valid. Bit counter resets to 0.
- Holding register keeps its contents.

TX handshake:
- Transfer occurs when i_tx_valid & o_tx_ready. o_tx_ready=0 the following cycle.
- When a load and a write fall in the same cycle, the load sees the pre-write holding state (no bypass): an empty holding register causes an underrun, and the written byte is kept for the next load.
- o_tx_ready returns to 1 the cycle after the holding register is consumed.

SCK edges while in IDLE are ignored.

Test Plan:
- Reset checks: hold i_rst_n=0 with SS low and SCK toggling, then release → all reset values hold; no pulses until SS rises and falls again.
- Single byte: preload tx 8'hA5, master sends 8'h3C in one 8-bit frame → master reads 8'hA5; o_rx_data=8'h3C with a single o_rx_valid pulse; o_frame_start and o_frame_end pulse once each; o_tx_ready back to 1.
- Multi-byte: master sends 8'h40,8'h00,8'h95 in one SS-low frame with tx 8'h01,8'h02 queued just in time → MISO returns 01,02,FF; one o_tx_underrun pulse on the third load; three o_rx_valid pulses carrying 40,00,95.
- Underrun at start: no tx preloaded, frame of 8'h77 → MISO returns FF; o_tx_underrun pulses at frame start; rx = 77.
- Abort: SS deasserted after 5 SCK rises → no o_rx_valid; next frame of 8'hC3 received correctly from bit 0.
- Same-cycle collision: i_tx_valid coincides with the load cycle while holding is empty → underrun, FF sent; that byte appears as the next byte on MISO.
